// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK modulator: width defaults, FSM state type and
// the carrier cosine table generator.
package bpsk_pkg;

  localparam int DEF_PHASE_W = 32;
  localparam int DEF_ANGLE_W = 10;
  localparam int DEF_AMP_W   = 16;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  // Peak is 2^(amp_w-1)-1 rather than 2^(amp_w-1) so the negated carrier always fits.
  function automatic int cos_entry(input int idx, input int angle_w, input int amp_w);
    real full;
    real v;
    full = real'((1 << (amp_w - 1)) - 1);
    v    = full * $cos(2.0 * PI * real'(idx) / real'(1 << angle_w));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

endpackage

// File: rtl/bpsk_modulator_carrier_rom.sv
// Combinational cosine lookup: one full carrier period over 2^ANGLE_W entries.
module carrier_rom
  import bpsk_pkg::*;
#(
  parameter int ANGLE_W = DEF_ANGLE_W,
  parameter int AMP_W   = DEF_AMP_W
) (
  input  logic        [ANGLE_W-1:0] angle,
  output logic signed [AMP_W-1:0]   cos_out
);

  localparam int DEPTH = 1 << ANGLE_W;

  // NOTE: the table is elaboration-time constants, so there is no storage to reset.
  logic signed [AMP_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic signed [AMP_W-1:0] VAL = AMP_W'(cos_entry(i, ANGLE_W, AMP_W));
    assign rom[i] = VAL;
  end

  assign cos_out = rom[angle];

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: one-deep bit hold register feeding a phase-continuous NCO whose
// carrier is sign-flipped per symbol; SPS samples are emitted per bit.
module bpsk_modulator
  import bpsk_pkg::*;
#(
  parameter int SPS     = 64,
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ANGLE_W = DEF_ANGLE_W,
  parameter int AMP_W   = DEF_AMP_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PHASE_W-1:0]      tuning_word,
  input  logic                    tx_en,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic signed [AMP_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    sym_strobe,
  output logic                    busy,
  output logic                    underrun
);

  localparam int               CNT_W    = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPS - 1);

  state_t                  state;
  logic                    hold_full;
  logic                    hold_bit;
  logic                    cur_bit;
  logic                    ready_en;
  logic [CNT_W-1:0]        cnt;
  logic [PHASE_W-1:0]      phase;
  logic signed [AMP_W-1:0] cos_val;
  logic                    accept;
  logic                    sym_end;

  carrier_rom #(
    .ANGLE_W (ANGLE_W),
    .AMP_W   (AMP_W)
  ) u_rom (
    .angle   (phase[PHASE_W-1 -: ANGLE_W]),
    .cos_out (cos_val)
  );

  // ready_en keeps bit_ready low until the first edge after reset is released.
  assign bit_ready = ready_en && !hold_full;
  assign accept    = bit_valid && bit_ready;
  assign sym_end   = (cnt == LAST_CNT);
  assign busy      = (state == TX);

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; blocking writes would leak updates into later statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      hold_full    <= 1'b0;
      hold_bit     <= 1'b0;
      cur_bit      <= 1'b0;
      cnt          <= '0;
      phase        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sym_strobe   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;

      // Accept needs an empty hold and every load needs a full one, so they never collide.
      if (accept) begin
        hold_full <= 1'b1;
        hold_bit  <= bit_in;
      end

      unique case (state)
        IDLE: begin
          sample_valid <= 1'b0;
          sample_out   <= '0;
          if (hold_full && tx_en) begin
            state     <= TX;
            cur_bit   <= hold_bit;
            hold_full <= 1'b0;
            cnt       <= '0;
            phase     <= '0;
          end
        end

        TX: begin
          sample_out   <= cur_bit ? -cos_val : cos_val;
          sample_valid <= 1'b1;
          phase        <= phase + tuning_word;
          cnt          <= cnt + 1'b1;
          if (sym_end) begin
            sym_strobe <= 1'b1;
            cnt        <= '0;
            if (tx_en && hold_full) begin
              cur_bit   <= hold_bit;
              hold_full <= 1'b0;
            end else begin
              state    <= IDLE;
              underrun <= tx_en;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator (SPS=4): directed latency/boundary cases
// plus randomized bit streams checked against a math-level carrier model.
module tb_bpsk_modulator;

  localparam int  SPS  = 4;
  localparam int  FULL = 32767;
  localparam real PI   = 3.14159265358979323846;

  logic               clk         = 1'b0;
  logic               reset       = 1'b1;
  logic [31:0]        tuning_word = '0;
  logic               tx_en       = 1'b0;
  logic               bit_in      = 1'b0;
  logic               bit_valid   = 1'b0;
  logic               bit_ready;
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               sym_strobe;
  logic               busy;
  logic               underrun;

  int n_assert = 0;
  int n_fail   = 0;

  bit tx_bits[$];
  int exp_samp[$];

  bpsk_modulator #(
    .SPS     (SPS),
    .PHASE_W (32),
    .ANGLE_W (10),
    .AMP_W   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tuning_word  (tuning_word),
    .tx_en        (tx_en),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sym_strobe   (sym_strobe),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Sample k after TX entry: phase = k*tw mod 2^32, top 10 bits index one carrier period.
  function automatic int model_sample(input bit b, input int k, input logic [31:0] tw);
    logic [31:0] ph;
    int          ang;
    real         v;
    int          m;
    ph  = 32'(k) * tw;
    ang = int'(ph >> 22);
    v   = 32767.0 * $cos(2.0 * PI * real'(ang) / 1024.0);
    m   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return b ? -m : m;
  endfunction

  // Streams tx_bits with bit_valid held high, expects exp_samp back to back, then underrun.
  task automatic run_stream(input string tag);
    int nbits, nexp, sent, got, budget;
    bit acc;
    nbits  = tx_bits.size();
    nexp   = exp_samp.size();
    sent   = 0;
    got    = 0;
    budget = nbits * SPS + 10;
    tx_en  = 1'b1;
    for (int cyc = 0; cyc < budget && got < nexp; cyc++) begin
      bit_valid = (sent < nbits);
      bit_in    = (sent < nbits) ? tx_bits[sent] : 1'b0;
      acc       = bit_valid && bit_ready;
      step();
      if (acc) begin
        sent++;
        chk({tag, "_ready_low_when_held"}, 32'(bit_ready), 0);
      end
      if (sample_valid) begin
        chk({tag, "_sample"}, 32'(sample_out), exp_samp[got]);
        chk({tag, "_strobe"}, 32'(sym_strobe), 32'((got % SPS) == SPS - 1));
        chk({tag, "_underrun"}, 32'(underrun), 32'(got == nexp - 1));
        got++;
      end else if (got > 0) begin
        chk({tag, "_gap"}, 32'(sample_valid), 1);
      end
    end
    bit_valid = 1'b0;
    chk({tag, "_sample_count"}, got, nexp);
    step();
    chk({tag, "_valid_after_end"}, 32'(sample_valid), 0);
    chk({tag, "_busy_after_end"}, 32'(busy), 0);
    chk({tag, "_underrun_once"}, 32'(underrun), 0);
  endtask

  initial begin
    int nb;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_out", 32'(sample_out), 0);
    chk("rst_ready", 32'(bit_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobe", 32'(sym_strobe), 0);
    chk("rst_underrun", 32'(underrun), 0);
    reset = 1'b0;
    chk("ready_at_release", 32'(bit_ready), 0);
    step();
    chk("ready_after_release", 32'(bit_ready), 1);

    // DC carrier, bits 0,1
    tuning_word = 32'd0;
    tx_bits  = '{1'b0, 1'b1};
    exp_samp = '{FULL, FULL, FULL, FULL, -FULL, -FULL, -FULL, -FULL};
    run_stream("tw0_01");

    // Quarter-turn per sample, bits 0,1 with continuous phase
    tuning_word = 32'h4000_0000;
    tx_bits  = '{1'b0, 1'b1};
    exp_samp = '{FULL, 0, -FULL, 0, -FULL, 0, FULL, 0};
    run_stream("quarter_01");

    // Held-valid sequence 1,0,1,1
    tuning_word = 32'd0;
    tx_bits  = '{1'b1, 1'b0, 1'b1, 1'b1};
    exp_samp = '{-FULL, -FULL, -FULL, -FULL, FULL, FULL, FULL, FULL,
                 -FULL, -FULL, -FULL, -FULL, -FULL, -FULL, -FULL, -FULL};
    run_stream("seq_1011");

    // tx_en dropped mid-symbol with a bit held
    tuning_word = 32'h4000_0000;
    tx_en     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    step();
    chk("drop_ready_full", 32'(bit_ready), 0);
    bit_in = 1'b1;
    step();
    chk("drop_latency", 32'(sample_valid), 0);
    chk("drop_busy", 32'(busy), 1);
    chk("drop_ready_free", 32'(bit_ready), 1);
    step();
    bit_valid = 1'b0;
    chk("drop_s1_valid", 32'(sample_valid), 1);
    chk("drop_s1", 32'(sample_out), FULL);
    step();
    chk("drop_s2", 32'(sample_out), 0);
    tx_en = 1'b0;
    step();
    chk("drop_s3", 32'(sample_out), -FULL);
    step();
    chk("drop_s4", 32'(sample_out), 0);
    chk("drop_s4_strobe", 32'(sym_strobe), 1);
    chk("drop_s4_no_underrun", 32'(underrun), 0);
    step();
    chk("drop_idle_valid", 32'(sample_valid), 0);
    chk("drop_idle_busy", 32'(busy), 0);
    chk("drop_bit_retained", 32'(bit_ready), 0);
    repeat (3) step();
    chk("drop_still_idle", 32'(sample_valid), 0);
    tx_en = 1'b1;
    step();
    chk("resume_latency", 32'(sample_valid), 0);
    step();
    chk("resume_s1", 32'(sample_out), -FULL);
    step();
    chk("resume_s2", 32'(sample_out), 0);
    step();
    chk("resume_s3", 32'(sample_out), FULL);
    step();
    chk("resume_s4", 32'(sample_out), 0);
    chk("resume_underrun", 32'(underrun), 1);
    step();
    chk("resume_end_valid", 32'(sample_valid), 0);

    // Reset asserted mid-symbol
    tuning_word = 32'd0;
    bit_valid   = 1'b1;
    bit_in      = 1'b0;
    step();
    bit_in = 1'b1;
    step();
    step();
    bit_valid = 1'b0;
    step();
    chk("pre_rst_valid", 32'(sample_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(sample_valid), 0);
    chk("mid_rst_out", 32'(sample_out), 0);
    chk("mid_rst_ready", 32'(bit_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    step();
    chk("mid_rst_ready_held", 32'(bit_ready), 0);
    reset = 1'b0;
    chk("mid_rst_ready_release", 32'(bit_ready), 0);
    step();
    chk("mid_rst_ready_rise", 32'(bit_ready), 1);
    repeat (SPS + 2) step();
    chk("mid_rst_held_dropped", 32'(sample_valid), 0);
    chk("mid_rst_idle", 32'(busy), 0);

    // Randomized streams against the carrier model
    for (int r = 0; r < 8; r++) begin
      tuning_word = (r == 0) ? 32'(($urandom_range(1, 4095) << 8)) : $urandom;
      nb = $urandom_range(2, 8);
      tx_bits.delete();
      exp_samp.delete();
      for (int b = 0; b < nb; b++) tx_bits.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < nb * SPS; k++)
        exp_samp.push_back(model_sample(tx_bits[k / SPS], k, tuning_word));
      run_stream("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
